bcd_digit_entry: RTL and testbench
==================================

// Module: bcd_digit_entry
// PURPOSE
//   Keypad-driven entry stage that feeds BCD2BinarySM. Collects up to 3 decimal digits plus a sign
//   from one-cycle key strobes and assembles the 16-bit sign/BCD word {sign,3'b000,d2,d1,d0}.
//   On ENTER it range-checks the magnitude and presents the word with a valid/ready handshake.
//   The converter then sees only in-range values. Its invalid flag becomes a backstop only.
// PARAMETERS
//   MAX_MAG   127   largest magnitude accepted on ENTER (decimal)
//   ALLOW_NEG 1     1: SIGN key toggles sign; 0: SIGN key ignored, sign forced to 0
// PORTS
//   clk          in   1   system clock, rising edge
//   rst_n        in   1   reset, asynchronous, active-low
//   key_valid    in   1   one-cycle strobe: key_code is valid this cycle
//   key_code     in   4   0-9 digit; A=SIGN; B=CLEAR; C=ENTER; D=BACKSPACE; E,F ignored
//   bcd_ready    in   1   downstream accepts bcd_out when bcd_valid=1
//   bcd_out      out  16  {sign,3'b000,d2,d1,d0}; [14:12] always 0
//   bcd_valid    out  1   committed word available (HOLD state)
//   digit_count  out  2   digits currently entered, 0..3
//   err          out  1   one-cycle pulse on a rejected key (see below)
// BEHAVIOUR
//   Reset: state=IDLE; bcd_out=16'h0000; bcd_valid=0; digit_count=0; err=0.
//   All outputs registered. A key acts on the clock edge where key_valid=1. Effect is visible next cycle.
//   States:
//     IDLE  (count=0)  --digit--> ENTRY.
//     ENTRY (count 1..3).
//     HOLD  (bcd_valid=1).
//   Digit key: {d2,d1,d0} <= {d1,d0,key}; count++. Leading zeros count as digits.
//   Digit key with count=3: register unchanged; err pulse.
//   BACKSPACE: {d2,d1,d0} <= {0,d2,d1}; count--. At count=0 the key is ignored, with no err.
//     If count reaches 0, go to IDLE. Sign is kept.
//   SIGN: sign <= ~sign in IDLE/ENTRY (ALLOW_NEG=1). Ignored when ALLOW_NEG=0.
//   CLEAR: digits, sign and count reset to 0; go to IDLE. Valid in IDLE and ENTRY.
//   ENTER in IDLE: ignored.
//   ENTER in ENTRY, magnitude <= MAX_MAG: go to HOLD.
//     A magnitude of 0 forces sign=0, so -0 becomes +0.
//   ENTER in ENTRY, magnitude > MAX_MAG: err pulse; stay in ENTRY with the register unchanged.
//   HOLD: bcd_out stable; all keys ignored, with no err.
//     On bcd_valid && bcd_ready: next cycle state=IDLE, register cleared, bcd_valid=0.
//     A key arriving in the transfer cycle is dropped.
//   Outside HOLD, bcd_out shows the live in-progress word (display use). Downstream must qualify it with bcd_valid.
//   Magnitude compare: d2*100+d1*10+d0 is formed in 7+ bits. Never compare raw BCD bits.
//   Codes E/F: no effect in any state.
//   Asynchronous reset mid-entry or mid-HOLD: immediate return to reset values. The pending word is lost.
// STRUCTURE
//   Package bcd_entry_pkg:
//     key code localparams KEY_SIGN=4'hA, KEY_CLR=4'hB, KEY_ENT=4'hC, KEY_BS=4'hD.
//     state encoding IDLE/ENTRY/HOLD as 2-bit localparams.
//   Sub-module bcd_key_decode (combinational):
//     key_code -> is_digit/is_sign/is_clr/is_ent/is_bs one-hot flags.
//   Top holds the FSM, digit shift register, count, sign and range compare.
// TESTING
//   1. Keys 1,2,7,ENTER, hold ready=0 for 5 cycles -> bcd_out=16'h0127, bcd_valid held 5 cycles.
//      Then ready=1 -> IDLE, bcd_out=0.
//   2. SIGN,4,2,ENTER, ready=1 -> bcd_out=16'h8042 for exactly one valid cycle.
//   3. Keys 1,2,8,ENTER -> err pulse, state ENTRY, digit_count=3, bcd_valid=0.
//      Then BS,ENTER -> bcd_out=16'h0012 valid.
//   4. Keys 9,9,9,5 -> err on the 4th digit, bcd_out=16'h0999.
//      Then CLEAR -> 16'h0000, count=0.
//   5. SIGN,0,ENTER -> bcd_out=16'h0000 (no -0).
//      Keys pressed during HOLD -> ignored, no err.
//   6. rst_n low mid-entry (after 3,4) and mid-HOLD -> all outputs at reset values same cycle.
//      Normal entry works after release.

Source files
------------

// File: rtl/bcd_entry_pkg.sv
// Shared key codes, FSM state encoding and the BCD magnitude helper
// for the keypad digit-entry stage.
package bcd_entry_pkg;

   localparam logic [3:0] KEY_SIGN = 4'hA;
   localparam logic [3:0] KEY_CLR  = 4'hB;
   localparam logic [3:0] KEY_ENT  = 4'hC;
   localparam logic [3:0] KEY_BS   = 4'hD;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ENTRY = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   localparam logic [1:0] MAX_DIGITS = 2'd3;

   // Binary value of three BCD digits; 10 bits covers 0..999.
   function automatic logic [9:0] bcd_magnitude(input logic [3:0] d2,
                                                input logic [3:0] d1,
                                                input logic [3:0] d0);
      return ({6'd0, d2} * 10'd100) + ({6'd0, d1} * 10'd10) + {6'd0, d0};
   endfunction

endpackage

// File: rtl/bcd_key_decode.sv
// Combinational keypad decoder: raw 4-bit key code to one-hot class flags.
// Codes E and F raise no flag.
module bcd_key_decode
   import bcd_entry_pkg::*;
(
   input  logic [3:0] i_key_code,
   output logic       o_is_digit,
   output logic       o_is_sign,
   output logic       o_is_clr,
   output logic       o_is_ent,
   output logic       o_is_bs
);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      o_is_digit = 1'b0;
      o_is_sign  = 1'b0;
      o_is_clr   = 1'b0;
      o_is_ent   = 1'b0;
      o_is_bs    = 1'b0;
      if (i_key_code <= 4'd9) begin
         o_is_digit = 1'b1;
      end else begin
         case (i_key_code)
            KEY_SIGN: o_is_sign = 1'b1;
            KEY_CLR:  o_is_clr  = 1'b1;
            KEY_ENT:  o_is_ent  = 1'b1;
            KEY_BS:   o_is_bs   = 1'b1;
            default:  ;
         endcase
      end
   end

endmodule

// File: rtl/bcd_digit_entry.sv
// Keypad entry stage: collects up to three BCD digits and a sign, range-checks
// on ENTER and offers {sign,3'b000,d2,d1,d0} through a valid/ready handshake.
module bcd_digit_entry
   import bcd_entry_pkg::*;
#(
   parameter int unsigned MAX_MAG   = 127,
   parameter bit          ALLOW_NEG = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   input  logic        bcd_ready,
   output logic [15:0] bcd_out,
   output logic        bcd_valid,
   output logic [1:0]  digit_count,
   output logic        err
);

   localparam logic [9:0] MAX_MAG_W = 10'(MAX_MAG);

   logic [1:0] r_state;
   logic [1:0] w_state_nxt;
   logic [3:0] r_d2, r_d1, r_d0;
   logic [3:0] w_d2_nxt, w_d1_nxt, w_d0_nxt;
   logic       r_sign, w_sign_nxt;
   logic [1:0] r_count, w_count_nxt;
   logic       r_valid, w_valid_nxt;
   logic       r_err, w_err_nxt;

   logic       w_is_digit, w_is_sign, w_is_clr, w_is_ent, w_is_bs;
   logic [9:0] w_mag;
   logic       w_in_range;

   bcd_key_decode u_decode (
      .i_key_code (key_code),
      .o_is_digit (w_is_digit),
      .o_is_sign  (w_is_sign),
      .o_is_clr   (w_is_clr),
      .o_is_ent   (w_is_ent),
      .o_is_bs    (w_is_bs)
   );

   // Range check on the binary value, never on the raw BCD nibbles.
   assign w_mag      = bcd_magnitude(r_d2, r_d1, r_d0);
   assign w_in_range = (w_mag <= MAX_MAG_W);

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (key_valid && w_is_digit) w_state_nxt = ST_ENTRY;
         end
         ST_ENTRY: begin
            if (key_valid) begin
               if (w_is_clr)                            w_state_nxt = ST_IDLE;
               else if (w_is_bs && (r_count == 2'd1))   w_state_nxt = ST_IDLE;
               else if (w_is_ent && w_in_range)         w_state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (bcd_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_d2_nxt    = r_d2;
      w_d1_nxt    = r_d1;
      w_d0_nxt    = r_d0;
      w_sign_nxt  = r_sign;
      w_count_nxt = r_count;
      w_err_nxt   = 1'b0;
      case (r_state)
         ST_IDLE, ST_ENTRY: begin
            if (key_valid) begin
               if (w_is_digit) begin
                  if (r_count == MAX_DIGITS) begin
                     w_err_nxt = 1'b1;
                  end else begin
                     w_d2_nxt    = r_d1;
                     w_d1_nxt    = r_d0;
                     w_d0_nxt    = key_code;
                     w_count_nxt = r_count + 2'd1;
                  end
               end else if (w_is_bs) begin
                  if (r_count != 2'd0) begin
                     w_d2_nxt    = 4'd0;
                     w_d1_nxt    = r_d2;
                     w_d0_nxt    = r_d1;
                     w_count_nxt = r_count - 2'd1;
                  end
               end else if (w_is_sign) begin
                  if (ALLOW_NEG) w_sign_nxt = ~r_sign;
               end else if (w_is_clr) begin
                  w_d2_nxt    = 4'd0;
                  w_d1_nxt    = 4'd0;
                  w_d0_nxt    = 4'd0;
                  w_sign_nxt  = 1'b0;
                  w_count_nxt = 2'd0;
               end else if (w_is_ent && (r_state == ST_ENTRY)) begin
                  // A zero magnitude is always committed as +0.
                  if (!w_in_range)         w_err_nxt  = 1'b1;
                  else if (w_mag == 10'd0) w_sign_nxt = 1'b0;
               end
            end
         end
         ST_HOLD: begin
            if (bcd_ready) begin
               w_d2_nxt    = 4'd0;
               w_d1_nxt    = 4'd0;
               w_d0_nxt    = 4'd0;
               w_sign_nxt  = 1'b0;
               w_count_nxt = 2'd0;
            end
         end
         default: begin
            w_d2_nxt    = 4'd0;
            w_d1_nxt    = 4'd0;
            w_d0_nxt    = 4'd0;
            w_sign_nxt  = 1'b0;
            w_count_nxt = 2'd0;
         end
      endcase
      w_valid_nxt = (w_state_nxt == ST_HOLD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d2    <= 4'd0;
         r_d1    <= 4'd0;
         r_d0    <= 4'd0;
         r_sign  <= 1'b0;
         r_count <= 2'd0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_d2    <= w_d2_nxt;
         r_d1    <= w_d1_nxt;
         r_d0    <= w_d0_nxt;
         r_sign  <= w_sign_nxt;
         r_count <= w_count_nxt;
         r_valid <= w_valid_nxt;
         r_err   <= w_err_nxt;
      end
   end

   assign bcd_out     = {r_sign, 3'b000, r_d2, r_d1, r_d0};
   assign bcd_valid   = r_valid;
   assign digit_count = r_count;
   assign err         = r_err;

endmodule

// File: tb/tb_bcd_digit_entry.sv
// Directed self-checking bench for bcd_digit_entry: entry, range check,
// handshake, HOLD key masking and asynchronous reset.
module tb_bcd_digit_entry;
   import bcd_entry_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        bcd_ready;
   logic [15:0] bcd_out;
   logic        bcd_valid;
   logic [1:0]  digit_count;
   logic        err;

   int checks   = 0;
   int failures = 0;

   bcd_digit_entry #(.MAX_MAG(127), .ALLOW_NEG(1'b1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .bcd_ready   (bcd_ready),
      .bcd_out     (bcd_out),
      .bcd_valid   (bcd_valid),
      .digit_count (digit_count),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic check_all(input string tag, input logic [15:0] e_out,
                            input logic e_valid, input logic [1:0] e_cnt,
                            input logic e_err);
      checks++;
      assert (bcd_out === e_out) else begin
         failures++;
         $error("FAIL %s bcd_out observed=%h expected=%h", tag, bcd_out, e_out);
      end
      checks++;
      assert (bcd_valid === e_valid) else begin
         failures++;
         $error("FAIL %s bcd_valid observed=%b expected=%b", tag, bcd_valid, e_valid);
      end
      checks++;
      assert (digit_count === e_cnt) else begin
         failures++;
         $error("FAIL %s digit_count observed=%0d expected=%0d", tag, digit_count, e_cnt);
      end
      checks++;
      assert (err === e_err) else begin
         failures++;
         $error("FAIL %s err observed=%b expected=%b", tag, err, e_err);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the key acted.
   task automatic key(input logic [3:0] code);
      key_valid = 1'b1;
      key_code  = code;
      @(negedge clk);
      key_valid = 1'b0;
      key_code  = 4'hF;
   endtask

   initial begin
      rst_n     = 1'b0;
      key_valid = 1'b0;
      key_code  = 4'hF;
      bcd_ready = 1'b0;
      #2;
      check_all("reset", 16'h0000, 1'b0, 2'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: 127 is accepted and held while ready is low
      key(4'd1);    check_all("t1_d1", 16'h0001, 1'b0, 2'd1, 1'b0);
      key(4'd2);    check_all("t1_d2", 16'h0012, 1'b0, 2'd2, 1'b0);
      key(4'd7);    check_all("t1_d3", 16'h0127, 1'b0, 2'd3, 1'b0);
      key(KEY_ENT); check_all("t1_ent", 16'h0127, 1'b1, 2'd3, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_all("t1_hold", 16'h0127, 1'b1, 2'd3, 1'b0);
      end
      bcd_ready = 1'b1;
      @(negedge clk);
      bcd_ready = 1'b0;
      check_all("t1_xfer", 16'h0000, 1'b0, 2'd0, 1'b0);

      // Idle-state keys with no effect
      key(4'hE);    check_all("idle_e", 16'h0000, 1'b0, 2'd0, 1'b0);
      key(KEY_BS);  check_all("idle_bs", 16'h0000, 1'b0, 2'd0, 1'b0);
      key(KEY_ENT); check_all("idle_ent", 16'h0000, 1'b0, 2'd0, 1'b0);

      // 2: negative value, ready already high -> one valid cycle
      bcd_ready = 1'b1;
      key(KEY_SIGN); check_all("t2_sign", 16'h8000, 1'b0, 2'd0, 1'b0);
      key(4'd4);     check_all("t2_d1", 16'h8004, 1'b0, 2'd1, 1'b0);
      key(4'd2);     check_all("t2_d2", 16'h8042, 1'b0, 2'd2, 1'b0);
      key(KEY_ENT);  check_all("t2_ent", 16'h8042, 1'b1, 2'd2, 1'b0);
      @(negedge clk);
      check_all("t2_xfer", 16'h0000, 1'b0, 2'd0, 1'b0);
      bcd_ready = 1'b0;

      // 3: 128 out of range, then backspace to 12
      key(4'd1); key(4'd2); key(4'd8);
      check_all("t3_128", 16'h0128, 1'b0, 2'd3, 1'b0);
      key(KEY_ENT); check_all("t3_rej", 16'h0128, 1'b0, 2'd3, 1'b1);
      @(negedge clk);
      check_all("t3_errclr", 16'h0128, 1'b0, 2'd3, 1'b0);
      key(KEY_BS);  check_all("t3_bs", 16'h0012, 1'b0, 2'd2, 1'b0);
      key(KEY_ENT); check_all("t3_ent", 16'h0012, 1'b1, 2'd2, 1'b0);
      bcd_ready = 1'b1;
      @(negedge clk);
      bcd_ready = 1'b0;
      check_all("t3_xfer", 16'h0000, 1'b0, 2'd0, 1'b0);

      // 4: fourth digit rejected, then CLEAR
      key(4'd9); key(4'd9); key(4'd9);
      check_all("t4_999", 16'h0999, 1'b0, 2'd3, 1'b0);
      key(4'd5);    check_all("t4_4th", 16'h0999, 1'b0, 2'd3, 1'b1);
      key(KEY_CLR); check_all("t4_clr", 16'h0000, 1'b0, 2'd0, 1'b0);

      // Sign survives backspace back to IDLE
      key(KEY_SIGN); key(4'd3);
      key(KEY_BS);  check_all("bs_sign", 16'h8000, 1'b0, 2'd0, 1'b0);
      key(KEY_CLR); check_all("bs_clr", 16'h0000, 1'b0, 2'd0, 1'b0);

      // 5: -0 commits as +0; keys ignored in HOLD; key in transfer cycle dropped
      key(KEY_SIGN); check_all("t5_sign", 16'h8000, 1'b0, 2'd0, 1'b0);
      key(4'd0);     check_all("t5_d0", 16'h8000, 1'b0, 2'd1, 1'b0);
      key(KEY_ENT);  check_all("t5_ent", 16'h0000, 1'b1, 2'd1, 1'b0);
      key(4'd5);     check_all("t5_hold_dig", 16'h0000, 1'b1, 2'd1, 1'b0);
      key(KEY_CLR);  check_all("t5_hold_clr", 16'h0000, 1'b1, 2'd1, 1'b0);
      key(KEY_SIGN); check_all("t5_hold_sign", 16'h0000, 1'b1, 2'd1, 1'b0);
      bcd_ready = 1'b1;
      key(4'd3);
      bcd_ready = 1'b0;
      check_all("t5_xfer_key", 16'h0000, 1'b0, 2'd0, 1'b0);
      @(negedge clk);
      check_all("t5_after", 16'h0000, 1'b0, 2'd0, 1'b0);

      // 6: asynchronous reset mid-entry and mid-HOLD
      key(4'd3); key(4'd4);
      check_all("t6_34", 16'h0034, 1'b0, 2'd2, 1'b0);
      #2 rst_n = 1'b0;
      #1 check_all("t6_rst_entry", 16'h0000, 1'b0, 2'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      key(4'd5);
      key(KEY_ENT); check_all("t6_hold", 16'h0005, 1'b1, 2'd1, 1'b0);
      #2 rst_n = 1'b0;
      #1 check_all("t6_rst_hold", 16'h0000, 1'b0, 2'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      key(4'd6);
      key(KEY_ENT); check_all("t6_again", 16'h0006, 1'b1, 2'd1, 1'b0);
      bcd_ready = 1'b1;
      @(negedge clk);
      bcd_ready = 1'b0;
      check_all("t6_xfer", 16'h0000, 1'b0, 2'd0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
